// File: rtl/fifo_class_read_arbiter.sv
// Strict-priority, packet-locked read arbiter over NUM_CLASS FWFT class FIFOs.
// Optional starvation aging: define FIFO_ARB_AGING_EN.
module fifo_class_read_arbiter #(
  parameter int NUM_CLASS = 2,
  parameter int TYPE_W = 3,
  parameter logic [TYPE_W-1:0] TAIL_TYPE = 3'b110,
  parameter logic [TYPE_W-1:0] SINGLE_TYPE = 3'b111,
  parameter int AGE_LIMIT = 15,
  localparam int SEL_W = (NUM_CLASS > 2) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CLASS-1:0]        fifo_empty,
  input  logic [NUM_CLASS*TYPE_W-1:0] head_type,
  input  logic                        bussy,
  output logic [NUM_CLASS-1:0]        fifo_read,
  output logic                        req,
  output logic [SEL_W-1:0]            fifo_sel,
  output logic                        locked
);

  if (NUM_CLASS < 2 || NUM_CLASS > 8 || AGE_LIMIT < 1) begin : g_bad_cfg
    $error("fifo_class_read_arbiter: bad NUM_CLASS/AGE_LIMIT");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_cls_q, lock_cls_d;
  logic [TYPE_W-1:0]  types [NUM_CLASS];
  logic [SEL_W-1:0]   hi_cls;
  logic [SEL_W-1:0]   cand_idle;
  logic [SEL_W-1:0]   cand;
  logic [TYPE_W-1:0]  cand_type;
  logic               any_ne;
  logic               req_int;
  logic               rd;
  logic               is_end;
  logic               age_sel;

  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      types[i] = head_type[i*TYPE_W +: TYPE_W];
    end
  end

  always_comb begin
    hi_cls = '0;
    any_ne = 1'b0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (!fifo_empty[i]) begin
        hi_cls = SEL_W'(i);
        any_ne = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_AGING_EN
  localparam int AGE_W =
    ($clog2(AGE_LIMIT + 1) > 4) ? $clog2(AGE_LIMIT + 1) : 4;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [SEL_W-1:0] lo_cls;
  logic [AGE_W-1:0] age_q, age_d;
  logic             lower_ne;

  always_comb begin
    lo_cls = '0;
    for (int i = NUM_CLASS - 1; i >= 0; i--) begin
      if (!fifo_empty[i]) begin
        lo_cls = SEL_W'(i);
      end
    end
  end

  assign age_sel   = (age_q >= AGE_W'(AGE_LIMIT));
  assign cand_idle = age_sel ? lo_cls : hi_cls;
  // a lower class is waiting exactly when the pick is not the lowest one
  assign lower_ne  = any_ne && (cand_idle != lo_cls);

  always_comb begin
    age_d = age_q;
    if (rd && state_q == IDLE) begin
      if (!lower_ne) begin
        age_d = '0;
      end else if (age_q != AGE_MAX) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign age_sel   = 1'b0;
  assign cand_idle = hi_cls;
`endif

  always_comb begin
    if (state_q == LOCK) begin
      cand    = lock_cls_q;
      req_int = !fifo_empty[lock_cls_q];
    end else begin
      cand    = cand_idle;
      req_int = any_ne;
    end
  end

  assign rd        = req_int & !bussy;
  assign cand_type = types[cand];
  assign is_end    = (cand_type == TAIL_TYPE) ||
                     (cand_type == SINGLE_TYPE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_cls_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cls_q <= lock_cls_d;
    end
  end

  // a SINGLE seen while locked is a protocol error; it closes the packet
  always_comb begin
    state_d    = state_q;
    lock_cls_d = lock_cls_q;
    if (rd) begin
      unique case (state_q)
        IDLE: begin
          if (!is_end) begin
            state_d    = LOCK;
            lock_cls_d = cand;
          end
        end
        LOCK: begin
          if (is_end) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // strobes are held off while reset is asserted
  always_comb begin
    fifo_read = '0;
    if (rd && !rst) begin
      fifo_read[cand] = 1'b1;
    end
    req      = req_int & !rst;
    fifo_sel = cand;
    locked   = (state_q == LOCK);
  end

endmodule

// File: tb/tb_fifo_class_read_arbiter.sv
// Randomised bench for fifo_class_read_arbiter with a packet-level model
// plus directed scenarios pinned to hand-computed values.
module tb_fifo_class_read_arbiter;

  localparam int NC = 2;
  localparam int TW = 3;
  localparam int AL = 3;
  localparam int DEPTH = 256;
  localparam logic [2:0] TAIL = 3'b110;
  localparam logic [2:0] SNGL = 3'b111;
`ifdef FIFO_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] fifo_empty;
  logic [NC*TW-1:0] head_type;
  logic          bussy;
  logic [NC-1:0] fifo_read;
  logic          req;
  logic [0:0]    fifo_sel;
  logic          locked;

  fifo_class_read_arbiter #(
    .NUM_CLASS(NC),
    .TYPE_W(TW),
    .AGE_LIMIT(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .head_type(head_type),
    .bussy(bussy),
    .fifo_read(fifo_read),
    .req(req),
    .fifo_sel(fifo_sel),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] mem [NC][DEPTH];
  int hd [NC];
  int cnt [NC];
  logic [NC-1:0] hide;

  int owner = -1;
  int age = 0;
  int rd_cls = -1;
  logic [NC-1:0] ne_s;

  logic [NC-1:0] s_read;
  logic s_req, s_locked;
  logic [0:0] s_sel;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic push(input int c, input logic [2:0] t);
    mem[c][(hd[c] + cnt[c]) % DEPTH] = t;
    cnt[c]++;
  endtask

  task automatic flush();
    for (int c = 0; c < NC; c++) begin
      hd[c] = 0;
      cnt[c] = 0;
    end
  endtask

  task automatic present();
    for (int c = 0; c < NC; c++) begin
      fifo_empty[c] = (cnt[c] == 0) || hide[c];
      head_type[c*TW +: TW] = (cnt[c] != 0) ? mem[c][hd[c]] : 3'b000;
    end
  endtask

  // Expected outputs from the packet-level rules
  task automatic check();
    int cand, hi, lo;
    bit er;
    logic [NC-1:0] ne;
    logic [NC-1:0] er_vec;
    if (rst) begin
      owner = -1;
      age = 0;
    end
    ne = ~fifo_empty;
    hi = 0;
    lo = 0;
    for (int c = 0; c < NC; c++) if (ne[c]) hi = c;
    for (int c = NC - 1; c >= 0; c--) if (ne[c]) lo = c;
    if (owner >= 0) begin
      cand = owner;
      er = ne[owner];
    end else begin
      cand = (AGING && age >= AL) ? lo : hi;
      er = (ne != 0);
    end
    if (rst) er = 1'b0;
    er_vec = '0;
    if (er && !bussy) er_vec[cand] = 1'b1;
    s_read = fifo_read;
    s_req = req;
    s_sel = fifo_sel;
    s_locked = locked;
    chk("fifo_read", 32'(fifo_read), 32'(er_vec));
    chk("req", 32'(req), 32'(er));
    chk("fifo_sel", 32'(fifo_sel), 32'(cand));
    chk("locked", 32'(locked), 32'(owner >= 0));
    rd_cls = (er && !bussy) ? cand : -1;
    ne_s = ne;
  endtask

  task automatic update();
    logic [2:0] t;
    bit is_end, lower;
    if (rst) begin
      owner = -1;
      age = 0;
      return;
    end
    if (rd_cls < 0) return;
    t = mem[rd_cls][hd[rd_cls]];
    is_end = (t == TAIL) || (t == SNGL);
    if (owner < 0) begin
      lower = 1'b0;
      for (int j = 0; j < rd_cls; j++) if (ne_s[j]) lower = 1'b1;
      age = lower ? ((age < 15) ? age + 1 : 15) : 0;
      if (!is_end) owner = rd_cls;
    end else if (is_end) begin
      owner = -1;
    end
    hd[rd_cls] = (hd[rd_cls] + 1) % DEPTH;
    cnt[rd_cls]--;
  endtask

  task automatic cycle();
    present();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic push_rand_pkt(input int c);
    int len;
    len = $urandom_range(1, 4);
    if (len == 1) begin
      push(c, ($urandom_range(0, 9) == 0) ? TAIL : SNGL);
    end else begin
      push(c, 3'($urandom_range(0, 5)));
      for (int k = 0; k < len - 2; k++) push(c, 3'($urandom_range(0, 5)));
      push(c, ($urandom_range(0, 19) == 0) ? SNGL : TAIL);
    end
  endtask

  initial begin
    int c0_reads;
    rst = 1'b1;
    bussy = 1'b0;
    hide = '0;
    flush();
    present();
    repeat (2) cycle();
    chk("rst_locked", 32'(s_locked), 32'd0);
    chk("rst_req", 32'(s_req), 32'd0);
    rst = 1'b0;
    cycle();

    // three-flit packet on class0
    push(0, 3'b100); push(0, 3'b000); push(0, 3'b110);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_read", 32'(s_read), (i < 3) ? 32'd1 : 32'd0);
      chk("t1_locked", 32'(s_locked), (i == 1 || i == 2) ? 32'd1 : 32'd0);
      chk("t1_req", 32'(s_req), (i < 3) ? 32'd1 : 32'd0);
    end

    // class1 arrives mid-packet and must wait for the tail
    push(0, 3'b100); push(0, 3'b000); push(0, 3'b000); push(0, 3'b110);
    cycle(); cycle();
    push(1, SNGL);
    cycle(); chk("t2_sel_body", 32'(s_sel), 32'd0);
    cycle(); chk("t2_sel_tail", 32'(s_sel), 32'd0);
    cycle(); chk("t2_read_c1", 32'(s_read), 32'd2);

    // locked on class1 with its FIFO empty
    push(1, 3'b100);
    cycle();
    push(0, SNGL);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t3_req", 32'(s_req), 32'd0);
      chk("t3_read", 32'(s_read), 32'd0);
      chk("t3_locked", 32'(s_locked), 32'd1);
      chk("t3_sel", 32'(s_sel), 32'd1);
    end
    push(1, TAIL);
    cycle(); chk("t3_resume", 32'(s_read), 32'd2);
    cycle(); chk("t3_c0_after", 32'(s_read), 32'd1);

    // bussy holds everything
    push(0, SNGL); push(1, SNGL);
    bussy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_read", 32'(s_read), 32'd0);
      chk("t4_req", 32'(s_req), 32'd1);
      chk("t4_locked", 32'(s_locked), 32'd0);
    end
    bussy = 1'b0;
    cycle(); chk("t4_c1", 32'(s_read), 32'd2);
    cycle(); chk("t4_c0", 32'(s_read), 32'd1);

    // async reset mid-packet
    push(1, 3'b100); push(1, 3'b000);
    cycle();
    present();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_locked_async", 32'(locked), 32'd0);
    chk("t5_read_async", 32'(fifo_read), 32'd0);
    flush();
    cycle();
    rst = 1'b0;
    push(1, SNGL);
    cycle();
    chk("t5_single", 32'(s_read), 32'd2);
    chk("t5_locked0", 32'(s_locked), 32'd0);
    cycle();
    chk("t5_locked1", 32'(s_locked), 32'd0);

    // both classes saturated with singles
    c0_reads = 0;
    for (int i = 0; i < 12; i++) begin
      while (cnt[0] < 4) push(0, SNGL);
      while (cnt[1] < 4) push(1, SNGL);
      cycle();
      if (s_read == 2'b01) c0_reads++;
    end
    chk("t6_c0_reads", 32'(c0_reads), AGING ? 32'd3 : 32'd0);
    flush();
    cycle();

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (cnt[c] < 200 && $urandom_range(0, 3) == 0) push_rand_pkt(c);
        hide[c] = ($urandom_range(0, 9) == 0);
      end
      bussy = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        flush();
        cycle();
        rst = 1'b0;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
